// File: rtl/dbg_trace_uart.sv
// Debug trace transmitter: snapshots CPU registers on each retire edge and
// streams them as a 14-byte 8N1 UART frame, with one pending slot of buffering.
module dbg_trace_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dbg_pc,
    input  logic [15:0] dbg_sp,
    input  logic [15:0] dbg_AF,
    input  logic [15:0] dbg_BC,
    input  logic [15:0] dbg_DE,
    input  logic [15:0] dbg_HL,
    input  logic        dbg_instruction_retired,
    input  logic        dbg_halted,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PAY_W  = 104;
    localparam int unsigned FRM_W  = 112;
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [3:0]       LAST_BYTE = 4'd13;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             r_state;
    state_t             n_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   n_cnt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         n_bit;
    logic [3:0]         r_byte_idx;
    logic [3:0]         n_byte;
    logic               r_tx;
    logic               n_tx;

    logic               r_ret_q;
    logic               r_act_valid;
    logic               r_act_halt;
    logic [FRM_W-1:0]   r_act_sh;
    logic               r_pend_valid;
    logic [PAY_W-1:0]   r_pend_data;
    logic [5:0]         r_seq;
    logic               r_drop_flag;
    logic [7:0]         r_drop_cnt;
    logic               r_halt_seen;
    logic               r_done;
    logic               r_busy;

    logic               w_last_cnt;
    logic               w_frame_end;
    logic               w_byte_adv;
    logic               w_capture;
    logic               w_pend_moves;
    logic               w_act_occ;
    logic               w_pend_occ;
    logic               w_cap_act;
    logic               w_cap_pend;
    logic               w_drop;
    logic               w_load_act;
    logic [PAY_W-1:0]   w_snap;
    logic [7:0]         w_cur_byte;
    logic [2:0]         w_bit_inc;

    assign w_last_cnt   = (r_cnt == LAST_CNT);
    assign w_frame_end  = (r_state == ST_STOP) && w_last_cnt && (r_byte_idx == LAST_BYTE);
    assign w_byte_adv   = (r_state == ST_STOP) && w_last_cnt && (r_byte_idx != LAST_BYTE);
    assign w_capture    = dbg_instruction_retired && !r_ret_q && !r_halt_seen;

    // A completing frame frees its slot before a same-cycle capture is placed
    assign w_pend_moves = w_frame_end && r_pend_valid;
    assign w_act_occ    = (r_act_valid && !w_frame_end) || w_pend_moves;
    assign w_pend_occ   = r_pend_valid && !w_frame_end;
    assign w_cap_act    = w_capture && !w_act_occ;
    assign w_cap_pend   = w_capture && w_act_occ && !w_pend_occ;
    assign w_drop       = w_capture && w_act_occ && w_pend_occ;
    assign w_load_act   = w_pend_moves || w_cap_act;

    assign w_snap     = {dbg_pc, dbg_sp, dbg_AF, dbg_BC, dbg_DE, dbg_HL,
                         dbg_halted, r_drop_flag, r_seq};
    assign w_cur_byte = r_act_sh[FRM_W-1 -: 8];
    assign w_bit_inc  = r_bit_idx + 3'd1;

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign drop_cnt = r_drop_cnt;

    // UART state register and bit/byte counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= n_state;
            r_cnt      <= n_cnt;
            r_bit_idx  <= n_bit;
            r_byte_idx <= n_byte;
            r_tx       <= n_tx;
        end
    end

    // UART next-state and next serial bit; a freshly loaded frame always starts with a start bit
    always_comb begin
        n_state = r_state;
        n_cnt   = r_cnt + 16'd1;
        n_bit   = r_bit_idx;
        n_byte  = r_byte_idx;
        n_tx    = r_tx;
        case (r_state)
            ST_IDLE: begin
                n_cnt = '0;
                n_tx  = 1'b1;
            end
            ST_START: begin
                if (w_last_cnt) begin
                    n_cnt   = '0;
                    n_bit   = '0;
                    n_state = ST_DATA;
                    n_tx    = w_cur_byte[0];
                end
            end
            ST_DATA: begin
                if (w_last_cnt) begin
                    n_cnt = '0;
                    if (r_bit_idx == 3'd7) begin
                        n_state = ST_STOP;
                        n_tx    = 1'b1;
                    end else begin
                        n_bit = w_bit_inc;
                        n_tx  = w_cur_byte[w_bit_inc];
                    end
                end
            end
            ST_STOP: begin
                if (w_last_cnt) begin
                    n_cnt = '0;
                    if (r_byte_idx == LAST_BYTE) begin
                        n_state = ST_IDLE;
                        n_tx    = 1'b1;
                    end else begin
                        n_byte  = r_byte_idx + 4'd1;
                        n_state = ST_START;
                        n_tx    = 1'b0;
                    end
                end
            end
            default: begin
                n_state = ST_IDLE;
            end
        endcase
        if (w_load_act) begin
            n_state = ST_START;
            n_cnt   = '0;
            n_bit   = '0;
            n_byte  = '0;
            n_tx    = 1'b0;
        end
    end

    // Active/pending snapshot slots; the active frame shifts out one byte per byte boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_valid  <= 1'b0;
            r_act_halt   <= 1'b0;
            r_act_sh     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            if (w_load_act) begin
                r_act_valid <= 1'b1;
                r_act_sh    <= {SYNC_BYTE, (w_pend_moves ? r_pend_data : w_snap)};
                r_act_halt  <= w_pend_moves ? r_pend_data[7] : dbg_halted;
            end else if (w_frame_end) begin
                r_act_valid <= 1'b0;
                r_act_halt  <= 1'b0;
            end else if (w_byte_adv) begin
                r_act_sh <= {r_act_sh[FRM_W-9:0], 8'h00};
            end

            if (w_cap_pend) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= w_snap;
            end else if (w_pend_moves) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Edge detect, sequence/drop bookkeeping, halt latch and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ret_q     <= 1'b0;
            r_seq       <= '0;
            r_drop_flag <= 1'b0;
            r_drop_cnt  <= '0;
            r_halt_seen <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ret_q <= dbg_instruction_retired;
            if (w_cap_act || w_cap_pend) begin
                r_seq       <= r_seq + 6'd1;
                r_drop_flag <= 1'b0;
                if (dbg_halted) begin
                    r_halt_seen <= 1'b1;
                end
            end
            if (w_drop) begin
                r_drop_flag <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            if (w_frame_end && r_act_halt) begin
                r_done <= 1'b1;
            end
            r_busy <= w_act_occ || w_cap_act || w_pend_occ || w_cap_pend;
        end
    end

endmodule

// File: tb/tb_dbg_trace_uart.sv
// Bench for dbg_trace_uart: a frame-schedule model predicts tx/busy/done/drop_cnt
// every cycle; a UART decoder on tx pins literal frame contents.
module tb_dbg_trace_uart;

    localparam int CPB     = 16;
    localparam int BYTE_T  = 10 * CPB;
    localparam int FRAME_T = 14 * BYTE_T;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc, sp, af, bc, de, hl;
    logic        ret, hlt;
    logic        tx, busy, done;
    logic [7:0]  drop_cnt;

    int n_cmp;
    int n_err;

    dbg_trace_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk                     (clk),
        .reset_n                 (rst_n),
        .dbg_pc                  (pc),
        .dbg_sp                  (sp),
        .dbg_AF                  (af),
        .dbg_BC                  (bc),
        .dbg_DE                  (de),
        .dbg_HL                  (hl),
        .dbg_instruction_retired (ret),
        .dbg_halted              (hlt),
        .tx                      (tx),
        .busy                    (busy),
        .done                    (done),
        .drop_cnt                (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model: schedule of accepted frames ----------------
    typedef struct {
        longint       cap;
        longint       st;
        longint       en;
        logic [111:0] data;
        bit           halted;
    } frm_t;

    frm_t   fq[$];
    longint cyc;
    bit     m_prev, m_halt, m_flag;
    int     m_seq, m_drop;
    int     m_inflight;
    longint m_last_en;
    frm_t   m_f;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            m_prev = 0; m_halt = 0; m_flag = 0;
            m_seq = 0; m_drop = 0; cyc = 0;
        end else begin
            cyc++;
            if (ret && !m_prev && !m_halt) begin
                m_inflight = 0;
                m_last_en  = -1;
                foreach (fq[i]) begin
                    if (fq[i].en >= cyc) begin
                        m_inflight++;
                        if (fq[i].en > m_last_en) m_last_en = fq[i].en;
                    end
                end
                if (m_inflight < 2) begin
                    m_f.cap    = cyc;
                    m_f.st     = (m_inflight == 0) ? cyc : m_last_en + 1;
                    m_f.en     = m_f.st + FRAME_T - 1;
                    m_f.data   = {8'hA5, pc, sp, af, bc, de, hl, hlt, m_flag, 6'(m_seq)};
                    m_f.halted = hlt;
                    fq.push_back(m_f);
                    m_seq  = (m_seq + 1) % 64;
                    m_flag = 0;
                    if (hlt) m_halt = 1;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_flag = 1;
                end
            end
            m_prev = ret;
        end
    end

    function automatic void model_outs(output logic etx, output logic ebusy, output logic edone);
        longint off;
        int     b, k;
        logic [7:0] byt;
        etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        foreach (fq[i]) begin
            if (fq[i].st <= cyc && cyc <= fq[i].en) begin
                off = cyc - fq[i].st;
                b   = int'(off / BYTE_T);
                k   = int'((off % BYTE_T) / CPB);
                byt = fq[i].data[111 - 8*b -: 8];
                if (k == 0)      etx = 1'b0;
                else if (k == 9) etx = 1'b1;
                else             etx = byt[k-1];
            end
            if (fq[i].cap <= cyc && cyc <= fq[i].en) ebusy = 1'b1;
            if (fq[i].halted && fq[i].en < cyc) edone = 1'b1;
        end
    endfunction

    function automatic void chk(string nm, logic [111:0] act, logic [111:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Per-cycle compare of all outputs against the model
    logic e_tx, e_busy, e_done;
    always @(negedge clk) begin
        if (rst_n) begin
            model_outs(e_tx, e_busy, e_done);
            chk("tx",       112'(tx),       112'(e_tx));
            chk("busy",     112'(busy),     112'(e_busy));
            chk("done",     112'(done),     112'(e_done));
            chk("drop_cnt", 112'(drop_cnt), 112'(m_drop));
        end
    end

    // ---------------- UART decoder on the DUT line ----------------
    logic [7:0] dec_q[$];
    bit         dec_on;
    int         dec_cnt;
    logic [7:0] dec_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            dec_on = 0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on  = 1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt >= CPB + CPB/2 && dec_cnt <= 8*CPB + CPB/2 && (dec_cnt % CPB) == CPB/2)
                dec_byte = {tx, dec_byte[7:1]};
            if (dec_cnt == 9*CPB + CPB/2) begin
                dec_q.push_back(dec_byte);
                dec_on = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ret = 1'b0; hlt = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        dec_q.delete();
    endtask

    task automatic rand_regs();
        pc = 16'($urandom); sp = 16'($urandom); af = 16'($urandom);
        bc = 16'($urandom); de = 16'($urandom); hl = 16'($urandom);
    endtask

    task automatic pulse();
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle timeout actual=busy required=idle");
        end
    endtask

    logic [7:0]   exp1[14];
    logic [111:0] exp1_w;
    int           bcount;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; ret = 1'b0; hlt = 1'b0;
        pc = '0; sp = '0; af = '0; bc = '0; de = '0; hl = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // reset state
        chk("rst_tx",   112'(tx),       112'(1));
        chk("rst_busy", 112'(busy),     112'(0));
        chk("rst_done", 112'(done),     112'(0));
        chk("rst_drop", 112'(drop_cnt), 112'(0));

        // single retire, literal frame
        exp1 = '{8'hA5, 8'h01, 8'h50, 8'hFF, 8'hFE, 8'h01, 8'hB0,
                 8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'h00};
        exp1_w = 112'hA5_0150_FFFE_01B0_0013_00D8_014D_00;
        pc = 16'h0150; sp = 16'hFFFE; af = 16'h01B0;
        bc = 16'h0013; de = 16'h00D8; hl = 16'h014D; hlt = 1'b0;
        pulse();
        chk("t1_tx_fall", 112'(tx),   112'(0));
        chk("t1_busy_up", 112'(busy), 112'(1));
        chk("t1_model_frame", (fq.size() > 0) ? fq[0].data : 112'(0), exp1_w);
        bcount = 0;
        while (busy === 1'b1 && bcount < 5000) begin
            bcount++;
            @(negedge clk);
        end
        chk("t1_busy_len", 112'(bcount), 112'(2240));
        tick(CPB);
        chk("t1_nbytes", 112'(dec_q.size()), 112'(14));
        for (int i = 0; i < 14; i++)
            chk("t1_byte", 112'((i < dec_q.size()) ? dec_q[i] : 8'hxx), 112'(exp1[i]));

        // three retires 5 cycles apart
        do_reset();
        rand_regs(); pulse(); tick(4);
        rand_regs(); pulse(); tick(4);
        rand_regs(); pulse();
        chk("t2_drop", 112'(drop_cnt), 112'(1));
        wait_idle(2*FRAME_T + 100);
        tick(CPB);
        chk("t2_nbytes", 112'(dec_q.size()), 112'(28));
        if (dec_q.size() >= 28) begin
            chk("t2_stat0", 112'(dec_q[13]), 112'(8'h00));
            chk("t2_stat1", 112'(dec_q[27]), 112'(8'h01));
        end
        rand_regs(); pulse();
        wait_idle(FRAME_T + 100);
        tick(CPB);
        chk("t2_nbytes2", 112'(dec_q.size()), 112'(42));
        if (dec_q.size() >= 42)
            chk("t2_stat2", 112'(dec_q[41]), 112'(8'h42));

        // strobe held for 50 cycles
        do_reset();
        rand_regs();
        ret = 1'b1; tick(50); ret = 1'b0;
        wait_idle(FRAME_T + 100);
        tick(CPB);
        chk("t3_nbytes", 112'(dec_q.size()), 112'(14));

        // 300 retires with both slots full: saturate
        for (int i = 0; i < 300; i++) begin
            rand_regs(); pulse(); tick(1);
        end
        chk("t4_sat", 112'(drop_cnt), 112'(255));
        wait_idle(2*FRAME_T + 100);
        chk("t4_sat_hold", 112'(drop_cnt), 112'(255));

        // randomized retire traffic
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rand_regs();
            ret = 1'b1; tick($urandom_range(1, 3)); ret = 1'b0;
            tick($urandom_range(1, 2000));
        end
        wait_idle(3*FRAME_T);

        // halted retire followed by two more
        do_reset();
        rand_regs(); hl = 16'h1234; hlt = 1'b1;
        pulse();
        hlt = 1'b0;
        tick(100); rand_regs(); pulse();
        tick(300); rand_regs(); pulse();
        chk("t6_drop", 112'(drop_cnt), 112'(0));
        chk("t6_done_early", 112'(done), 112'(0));
        wait_idle(FRAME_T + 100);
        chk("t6_done", 112'(done), 112'(1));
        tick(CPB);
        chk("t6_nbytes", 112'(dec_q.size()), 112'(14));
        if (dec_q.size() >= 14) begin
            chk("t6_hl_hi", 112'(dec_q[11]), 112'(8'h12));
            chk("t6_hl_lo", 112'(dec_q[12]), 112'(8'h34));
            chk("t6_stat",  112'(dec_q[13]), 112'(8'h80));
        end
        tick(FRAME_T / 4);
        chk("t6_no_more", 112'(busy), 112'(0));
        chk("t6_nbytes2", 112'(dec_q.size()), 112'(14));

        // reset at byte 6, bit 3
        do_reset();
        rand_regs(); af = 16'h0000; pulse();
        tick(3);
        rand_regs(); pulse();
        tick(6*BYTE_T + 4*CPB + 8 - 4);
        chk("t7_pre_tx", 112'(tx), 112'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_tx",   112'(tx),       112'(1));
        chk("t7_busy", 112'(busy),     112'(0));
        chk("t7_done", 112'(done),     112'(0));
        chk("t7_drop", 112'(drop_cnt), 112'(0));
        @(negedge clk);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        dec_q.delete();
        rand_regs(); pulse();
        wait_idle(FRAME_T + 100);
        tick(CPB);
        chk("t7_nbytes", 112'(dec_q.size()), 112'(14));
        if (dec_q.size() >= 14)
            chk("t7_seq0", 112'(dec_q[13]), 112'(8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
